// File: rtl/cordic_iter_ctrl_if.sv
// cordic_iter_ctrl_if
// Bundles every non-clock signal of the iterative CORDIC sequencer.
// The job source, the di_control_comp and the atan ROM all sit on the
// master side; the sequencer is the slave.
//   Job in      : start_input, mode_bit_input, x/y/z_input
//   Loop in     : di_input (direction), atan_input (ROM data)
//   Loop out    : x/y/z_cur_output, mode_cur_output, iter_idx_output (ROM address)
//   Job out     : busy_output, done_output, x/y/z_output
interface cordic_iter_ctrl_if #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_ITER  = 8
);
    localparam int ITER_WIDTH = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

    logic                         start_input;
    logic                         mode_bit_input;
    logic signed [BIT_WIDTH-1:0]  x_input;
    logic signed [BIT_WIDTH-1:0]  y_input;
    logic signed [BIT_WIDTH-1:0]  z_input;
    logic                         di_input;
    logic signed [BIT_WIDTH-1:0]  atan_input;

    logic signed [BIT_WIDTH-1:0]  x_cur_output;
    logic signed [BIT_WIDTH-1:0]  y_cur_output;
    logic signed [BIT_WIDTH-1:0]  z_cur_output;
    logic                         mode_cur_output;
    logic [ITER_WIDTH-1:0]        iter_idx_output;
    logic                         busy_output;
    logic                         done_output;
    logic signed [BIT_WIDTH-1:0]  x_output;
    logic signed [BIT_WIDTH-1:0]  y_output;
    logic signed [BIT_WIDTH-1:0]  z_output;

    modport master (
        output start_input, mode_bit_input, x_input, y_input, z_input,
        output di_input, atan_input,
        input  x_cur_output, y_cur_output, z_cur_output, mode_cur_output,
        input  iter_idx_output, busy_output, done_output,
        input  x_output, y_output, z_output
    );

    modport slave (
        input  start_input, mode_bit_input, x_input, y_input, z_input,
        input  di_input, atan_input,
        output x_cur_output, y_cur_output, z_cur_output, mode_cur_output,
        output iter_idx_output, busy_output, done_output,
        output x_output, y_output, z_output
    );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
// Iterative CORDIC sequencer: accepts one (x, y, z, mode) job in IDLE, runs
// NUM_ITER shift-add micro-rotations (one per clock) using the direction bit
// returned by an external di_control_comp and the angle from an external
// combinational atan ROM, then pulses done for one cycle with the results.
//   clk_input   : rising-edge clock
//   rst_n_input : asynchronous active-low reset
//   bus         : cordic_iter_ctrl_if slave (job, loop and result signals)
module cordic_iter_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_ITER  = 8
) (
    input  logic               clk_input,
    input  logic               rst_n_input,
    cordic_iter_ctrl_if.slave  bus
);
    localparam int ITER_WIDTH = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [ITER_WIDTH-1:0] LAST_IDX = ITER_WIDTH'(NUM_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic signed [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [BIT_WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic                        mode_q, mode_d;
    logic [ITER_WIDTH-1:0]       idx_q, idx_d;

    logic signed [BIT_WIDTH-1:0] x_sh, y_sh, x_rot, y_rot, z_rot;
    logic                        last_iter;

    assign last_iter = (idx_q == LAST_IDX);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_input) state_d = ITER;
            ITER:    if (last_iter)       state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from the next state and then registered, so busy/done are
    // glitch-free flops that line up exactly with the state they describe.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // ---------------- Datapath ----------------
    // Arithmetic shift keeps the sign of negative x/y (e.g. -16 >>> 1 = -8);
    // add/sub wrap naturally at BIT_WIDTH.
    always_comb begin
        x_sh  = x_q >>> idx_q;
        y_sh  = y_q >>> idx_q;
        x_rot = bus.di_input ? (x_q - y_sh) : (x_q + y_sh);
        y_rot = bus.di_input ? (y_q + x_sh) : (y_q - x_sh);
        z_rot = bus.di_input ? (z_q - bus.atan_input) : (z_q + bus.atan_input);

        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        mode_d = mode_q;
        idx_d  = idx_q;
        xo_d   = xo_q;
        yo_d   = yo_q;
        zo_d   = zo_q;

        case (state_q)
            IDLE: begin
                if (bus.start_input) begin
                    x_d    = bus.x_input;
                    y_d    = bus.y_input;
                    z_d    = bus.z_input;
                    mode_d = bus.mode_bit_input;
                    idx_d  = '0;
                end
            end
            ITER: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (last_iter) begin
                    // Index returns to 0 so the ROM address is 0 in DONE/IDLE.
                    idx_d = '0;
                    xo_d  = x_rot;
                    yo_d  = y_rot;
                    zo_d  = z_rot;
                end else begin
                    idx_d = idx_q + ITER_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
            xo_q   <= '0;
            yo_q   <= '0;
            zo_q   <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            mode_q <= mode_d;
            idx_q  <= idx_d;
            xo_q   <= xo_d;
            yo_q   <= yo_d;
            zo_q   <= zo_d;
        end
    end

    assign bus.x_cur_output    = x_q;
    assign bus.y_cur_output    = y_q;
    assign bus.z_cur_output    = z_q;
    assign bus.mode_cur_output = mode_q;
    assign bus.iter_idx_output = idx_q;
    assign bus.busy_output     = busy_q;
    assign bus.done_output     = done_q;
    assign bus.x_output        = xo_q;
    assign bus.y_output        = yo_q;
    assign bus.z_output        = zo_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl
// Closed-loop bench for cordic_iter_ctrl (BIT_WIDTH=8, NUM_ITER=4): a
// behavioural di_control_comp and atan ROM {32,19,10,5} close the loop.
// Jobs push their hand-computed results and done cycle into a scoreboard;
// a monitor pops and compares on every done pulse.
module tb_cordic_iter_ctrl;
    localparam int BW = 8;
    localparam int NI = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int x;
        int y;
        int z;
        int done_cyc;
    } exp_t;

    exp_t sb[$];

    cordic_iter_ctrl_if #(.BIT_WIDTH(BW), .NUM_ITER(NI)) bus ();

    cordic_iter_ctrl #(.BIT_WIDTH(BW), .NUM_ITER(NI)) dut (
        .clk_input   (clk),
        .rst_n_input (rst_n),
        .bus         (bus)
    );

    // di_control_comp: rotation drives z to 0, vectoring drives y to 0.
    assign bus.di_input = bus.mode_cur_output ? (bus.y_cur_output < 0)
                                              : (bus.z_cur_output >= 0);

    always_comb begin
        case (bus.iter_idx_output)
            2'd0:    bus.atan_input = 8'sd32;
            2'd1:    bus.atan_input = 8'sd19;
            2'd2:    bus.atan_input = 8'sd10;
            default: bus.atan_input = 8'sd5;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (rst_n && bus.done_output) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("x_output", int'(bus.x_output), e.x);
                check("y_output", int'(bus.y_output), e.y);
                check("z_output", int'(bus.z_output), e.z);
                check("done_latency", cyc, e.done_cyc);
                check("busy_in_done", int'(bus.busy_output), 1);
                check("idx_in_done", int'(bus.iter_idx_output), 0);
            end
        end
    end

    // Launch one job; inputs are scrambled right after acceptance to show
    // that mid-job input changes are ignored.
    task automatic start_job(input int x, input int y, input int z, input bit mode,
                             input bit expect_done, input int ex, input int ey, input int ez);
        @(negedge clk);
        bus.x_input        = BW'(x);
        bus.y_input        = BW'(y);
        bus.z_input        = BW'(z);
        bus.mode_bit_input = mode;
        bus.start_input    = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) sb.push_back('{ex, ey, ez, cyc + NI});
        bus.start_input    = 1'b0;
        bus.x_input        = 8'sh5A;
        bus.y_input        = -8'sd77;
        bus.z_input        = 8'sd99;
        bus.mode_bit_input = ~mode;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_pending", sb.size(), 0);
        // Settle into IDLE before the next job.
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x_cur"}, int'(bus.x_cur_output), 0);
        check({tag, "_y_cur"}, int'(bus.y_cur_output), 0);
        check({tag, "_z_cur"}, int'(bus.z_cur_output), 0);
        check({tag, "_mode_cur"}, int'(bus.mode_cur_output), 0);
        check({tag, "_iter_idx"}, int'(bus.iter_idx_output), 0);
        check({tag, "_busy"}, int'(bus.busy_output), 0);
        check({tag, "_done"}, int'(bus.done_output), 0);
        check({tag, "_x_out"}, int'(bus.x_output), 0);
        check({tag, "_y_out"}, int'(bus.y_output), 0);
        check({tag, "_z_out"}, int'(bus.z_output), 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.start_input    = 1'b0;
        bus.mode_bit_input = 1'b0;
        bus.x_input        = '0;
        bus.y_input        = '0;
        bus.z_input        = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(bus.busy_output), 0);
        check("idle_done", int'(bus.done_output), 0);

        // 1. Rotation.
        start_job(64, 0, 0, 1'b0, 1'b1, 105, -5, 2);
        check("busy_in_iter", int'(bus.busy_output), 1);
        drain();

        // 6 + 2. Vectoring; job 1 results held until job 2 completes.
        start_job(48, 32, 0, 1'b1, 1'b1, 94, -9, 28);
        @(posedge clk);
        #1;
        check("hold_x", int'(bus.x_output), 105);
        check("hold_y", int'(bus.y_output), -5);
        check("hold_z", int'(bus.z_output), 2);
        drain();
        repeat (3) @(negedge clk);
        check("keep_x", int'(bus.x_output), 94);
        check("keep_y", int'(bus.y_output), -9);
        check("keep_z", int'(bus.z_output), 28);

        // 5. Overflow: iteration 0 wraps y to -2.
        start_job(127, 127, 0, 1'b0, 1'b1, -3, 0, 2);
        drain();

        // 3. Start held high: one job per 6 cycles.
        @(negedge clk);
        bus.x_input        = 8'sd64;
        bus.y_input        = 8'sd0;
        bus.z_input        = 8'sd0;
        bus.mode_bit_input = 1'b0;
        bus.start_input    = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            sb.push_back('{105, -5, 2, cyc + NI});
            if (j < 2) repeat (5) @(posedge clk);
        end
        @(negedge clk);
        bus.start_input = 1'b0;
        drain();

        // 4. Reset in iteration 2 of a job: no done, all outputs cleared.
        start_job(64, 0, 0, 1'b0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_idx", int'(bus.iter_idx_output), 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_busy", int'(bus.busy_output), 0);
        start_job(64, 0, 0, 1'b0, 1'b1, 105, -5, 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
